// File: rtl/relu_maxpool_col.sv
// -----------------------------------------------------------------------------
// relu_maxpool_col
//
// Column-streaming ReLU + 2x2 max-pool stage placed after the layer-0
// convolution. Each input column (IN_ROWS FP16 values) is rectified and
// row-pooled in pairs on arrival. Even columns are parked in a half-height
// buffer; the following odd column is pooled against that buffer and one
// pooled column (IN_ROWS/2 values) is emitted. A 24x24 map therefore becomes a
// 12x12 map, one column per two input columns.
//
// Handshake: col_valid is a single-cycle pulse meaning "col_num/col_data are
// valid this cycle". There is no backpressure; a column can arrive every cycle
// and is always consumed (accepted, used as a restart, or dropped) in the cycle
// it is presented. Outputs are registered one-cycle pulses: pool_valid (with
// pool_col_num/pool_data), done (with the last pool_valid of a frame) and
// seq_err (out-of-sequence column). pool_data/pool_col_num hold between pulses.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   col_valid    in   input column present this cycle
//   col_num      in   index of the input column, 0..IN_COLS-1
//   col_data     in   FP16 column, element r = row r
//   pool_valid   out  pooled column valid (one-cycle pulse)
//   pool_col_num out  pooled column index, 0..IN_COLS/2-1
//   pool_data    out  pooled FP16 column
//   done         out  pulse with pool_valid of the last pooled column
//   seq_err      out  pulse one cycle after an out-of-sequence column
//   fsm_state    out  current FSM state (0 = EMPTY, 1 = HALF), for observation
// -----------------------------------------------------------------------------
module relu_maxpool_col #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_ROWS    = 24,
  parameter int IN_COLS    = 24,
  localparam int CW        = $clog2(IN_COLS) + 1,
  localparam int PCW       = $clog2(IN_COLS / 2) + 1,
  localparam int HR        = IN_ROWS / 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  col_valid,
  input  logic [CW-1:0]         col_num,
  input  logic [DATA_WIDTH-1:0] col_data [IN_ROWS-1:0],
  output logic                  pool_valid,
  output logic [PCW-1:0]        pool_col_num,
  output logic [DATA_WIDTH-1:0] pool_data [HR-1:0],
  output logic                  done,
  output logic                  seq_err,
  output logic [0:0]            fsm_state
);

  // Parameter sanity: pairs of rows and pairs of columns must exist.
  if ((IN_ROWS % 2) != 0) begin : g_rows_odd
    $error("relu_maxpool_col: IN_ROWS must be even");
  end
  if ((IN_COLS % 2) != 0) begin : g_cols_odd
    $error("relu_maxpool_col: IN_COLS must be even");
  end

  localparam logic [0:0] ST_EMPTY = 1'b0;  // no column held
  localparam logic [0:0] ST_HALF  = 1'b1;  // row-pooled even column held

  localparam logic [CW-1:0] LAST_COL = CW'(IN_COLS - 1);

  // ReLU on the raw bit pattern: anything with the sign bit set (negative
  // numbers, -0, negative NaN/Inf) becomes +0.
  function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] x);
    return x[DATA_WIDTH-1] ? '0 : x;
  endfunction

  // Both operands are already non-negative, so ordering of FP16 values equals
  // unsigned ordering of the magnitude bits. Positive NaN/Inf sort highest and
  // pass through untouched.
  function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    return (a[DATA_WIDTH-2:0] >= b[DATA_WIDTH-2:0]) ? a : b;
  endfunction

  logic [0:0]            state;
  logic [CW-1:0]         exp_col;
  logic [DATA_WIDTH-1:0] hold_buf [HR-1:0];
  logic [DATA_WIDTH-1:0] row_pool [HR-1:0];

  logic in_seq;
  logic restart;
  logic last_col;

  assign fsm_state = state;

  // Row pool of the presented column (ReLU then max over row pairs).
  always_comb begin
    for (int k = 0; k < HR; k++) begin
      row_pool[k] = fmax(relu(col_data[2*k]), relu(col_data[2*k+1]));
    end
  end

  // Column classification. A column 0 arriving when something else was
  // expected is treated as the start of a new frame rather than dropped, so
  // the stage resynchronises to the upstream engine without a reset.
  assign in_seq   = (col_num == exp_col);
  assign restart  = !in_seq && (col_num == '0);
  assign last_col = (col_num == LAST_COL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_EMPTY;
      exp_col      <= '0;
      pool_valid   <= 1'b0;
      pool_col_num <= '0;
      done         <= 1'b0;
      seq_err      <= 1'b0;
      for (int k = 0; k < HR; k++) begin
        hold_buf[k]  <= '0;
        pool_data[k] <= '0;
      end
    end else begin
      // Pulse outputs default low; data outputs hold.
      pool_valid <= 1'b0;
      done       <= 1'b0;
      seq_err    <= 1'b0;

      if (col_valid) begin
        if (in_seq) begin
          if (state == ST_EMPTY) begin
            // Even column: park the row-pooled values.
            for (int k = 0; k < HR; k++) begin
              hold_buf[k] <= row_pool[k];
            end
            state   <= ST_HALF;
            exp_col <= exp_col + CW'(1);
          end else begin
            // Odd column: finish the 2x2 window and emit.
            for (int k = 0; k < HR; k++) begin
              pool_data[k] <= fmax(hold_buf[k], row_pool[k]);
            end
            pool_col_num <= PCW'(col_num >> 1);
            pool_valid   <= 1'b1;
            state        <= ST_EMPTY;
            if (last_col) begin
              done    <= 1'b1;
              exp_col <= '0;
            end else begin
              exp_col <= exp_col + CW'(1);
            end
          end
        end else if (restart) begin
          // Drop whatever was held and take this column as column 0.
          seq_err <= 1'b1;
          for (int k = 0; k < HR; k++) begin
            hold_buf[k] <= row_pool[k];
          end
          state   <= ST_HALF;
          exp_col <= CW'(1);
        end else begin
          // Out of sequence and not a restart: discard, keep context.
          seq_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_relu_maxpool_col.sv
module tb_relu_maxpool_col;

  localparam int DW   = 16;
  localparam int ROWS = 24;
  localparam int COLS = 24;
  localparam int HR   = ROWS / 2;
  localparam int CW   = $clog2(COLS) + 1;
  localparam int PCW  = $clog2(COLS / 2) + 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          col_valid = 1'b0;
  logic [CW-1:0] col_num = '0;
  logic [DW-1:0] col_data [ROWS-1:0];
  logic          pool_valid;
  logic [PCW-1:0] pool_col_num;
  logic [DW-1:0] pool_data [HR-1:0];
  logic          done;
  logic          seq_err;
  logic [0:0]    fsm_state;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  relu_maxpool_col #(.DATA_WIDTH(DW), .IN_ROWS(ROWS), .IN_COLS(COLS)) dut (
    .clk(clk), .rst(rst), .col_valid(col_valid), .col_num(col_num),
    .col_data(col_data), .pool_valid(pool_valid), .pool_col_num(pool_col_num),
    .pool_data(pool_data), .done(done), .seq_err(seq_err), .fsm_state(fsm_state)
  );

  // FP16 encoding of a small non-negative integer (exact for n < 2048).
  function automatic logic [15:0] fp16_int(input int n);
    int e;
    logic [15:0] r;
    if (n <= 0) return 16'h0000;
    e = 0;
    for (int i = 0; i < 16; i++) if ((n >> i) != 0) e = i;
    r[15]    = 1'b0;
    r[14:10] = 5'(e + 15);
    r[9:0]   = 10'((n << (10 - e)) & 'h3FF);
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Called and returning on a falling edge; after return the outputs reflect
  // the column just presented.
  task automatic drive_col(input int n);
    col_valid = 1'b1;
    col_num   = CW'(n);
    @(negedge clk);
    col_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    col_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill_data(input logic [DW-1:0] v);
    for (int r = 0; r < ROWS; r++) col_data[r] = v;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    vec_cnt++;
    if (pool_valid !== 1'b0 || done !== 1'b0 || seq_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_pulses got pv=%b done=%b se=%b exp 0/0/0", pool_valid, done, seq_err);
    end
    vec_cnt++;
    if (pool_col_num !== '0 || fsm_state !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_state got pcn=%0d st=%b exp 0/0", pool_col_num, fsm_state);
    end
    for (int k = 0; k < HR; k++) begin
      vec_cnt++;
      if (pool_data[k] !== 16'h0000) begin
        err_cnt++;
        $display("FAIL reset_data k=%0d got=%h exp=0000", k, pool_data[k]);
      end
    end
  endtask

  task automatic test_ramp_frame();
    do_reset();
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) col_data[r] = fp16_int(r + c);
      drive_col(c);
      vec_cnt++;
      if (pool_valid !== (c % 2 == 1) || done !== (c == COLS - 1) || seq_err !== 1'b0) begin
        err_cnt++;
        $display("FAIL ramp_flags col=%0d got pv=%b done=%b se=%b exp pv=%0d done=%0d se=0",
                 c, pool_valid, done, seq_err, c % 2, c == COLS - 1);
      end
      if (c % 2 == 1) begin
        vec_cnt++;
        if (pool_col_num !== PCW'(c / 2)) begin
          err_cnt++;
          $display("FAIL ramp_colnum col=%0d got=%0d exp=%0d", c, pool_col_num, c / 2);
        end
        for (int k = 0; k < HR; k++) begin
          vec_cnt++;
          if (pool_data[k] !== fp16_int(2 * k + 1 + c)) begin
            err_cnt++;
            $display("FAIL ramp_data j=%0d k=%0d got=%h exp=%h", c / 2, k, pool_data[k],
                     fp16_int(2 * k + 1 + c));
          end
        end
      end else begin
        vec_cnt++;
        if (fsm_state !== 1'b1) begin
          err_cnt++;
          $display("FAIL ramp_half col=%0d got st=%b exp=1", c, fsm_state);
        end
      end
    end
    @(negedge clk);
    vec_cnt++;
    if (pool_valid !== 1'b0 || done !== 1'b0 || pool_col_num !== PCW'(11) || pool_data[0] !== fp16_int(24)) begin
      err_cnt++;
      $display("FAIL ramp_hold got pv=%b done=%b pcn=%0d d0=%h exp 0/0/11/%h",
               pool_valid, done, pool_col_num, pool_data[0], fp16_int(24));
    end
  endtask

  task automatic test_relu();
    do_reset();
    fill_data(16'hBC00);
    drive_col(0);
    fill_data(16'h8000);
    drive_col(1);
    vec_cnt++;
    if (pool_valid !== 1'b1 || pool_col_num !== '0) begin
      err_cnt++;
      $display("FAIL relu_out got pv=%b pcn=%0d exp 1/0", pool_valid, pool_col_num);
    end
    for (int k = 0; k < HR; k++) begin
      vec_cnt++;
      if (pool_data[k] !== 16'h0000) begin
        err_cnt++;
        $display("FAIL relu_data k=%0d got=%h exp=0000", k, pool_data[k]);
      end
    end
  endtask

  task automatic test_max_compare();
    logic [DW-1:0] q [4];
    for (int p = -1; p < 4; p++) begin
      q[0] = 16'h3800; q[1] = 16'h4000; q[2] = 16'h4200; q[3] = 16'hC500;
      if (p >= 0) q[p] = 16'h7E00;
      do_reset();
      fill_data(16'h0000);
      col_data[0] = q[0]; col_data[1] = q[1];
      col_data[2] = 16'h4400; col_data[3] = 16'hC800;
      drive_col(0);
      fill_data(16'h0000);
      col_data[0] = q[2]; col_data[1] = q[3];
      col_data[2] = 16'h3C00; col_data[3] = 16'h0000;
      drive_col(1);
      vec_cnt++;
      if (pool_data[0] !== ((p >= 0) ? 16'h7E00 : 16'h4200)) begin
        err_cnt++;
        $display("FAIL max_d0 nan_pos=%0d got=%h exp=%h", p, pool_data[0],
                 (p >= 0) ? 16'h7E00 : 16'h4200);
      end
      if (p < 0) begin
        vec_cnt++;
        if (pool_data[1] !== 16'h4400 || pool_data[2] !== 16'h0000) begin
          err_cnt++;
          $display("FAIL max_d12 got d1=%h d2=%h exp 4400/0000", pool_data[1], pool_data[2]);
        end
      end
    end
  endtask

  task automatic test_seq_err();
    do_reset();
    fill_data(16'h3C00);
    drive_col(0);
    drive_col(1);
    vec_cnt++;
    if (pool_valid !== 1'b1 || seq_err !== 1'b0 || pool_col_num !== PCW'(0)) begin
      err_cnt++;
      $display("FAIL seq_c1 got pv=%b se=%b pcn=%0d exp 1/0/0", pool_valid, seq_err, pool_col_num);
    end
    drive_col(3);
    vec_cnt++;
    if (seq_err !== 1'b1 || pool_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL seq_c3 got se=%b pv=%b exp 1/0", seq_err, pool_valid);
    end
    @(negedge clk);
    vec_cnt++;
    if (seq_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL seq_pulse got se=%b exp 0", seq_err);
    end
    drive_col(2);
    vec_cnt++;
    if (seq_err !== 1'b0 || pool_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL seq_c2 got se=%b pv=%b exp 0/0", seq_err, pool_valid);
    end
    drive_col(3);
    vec_cnt++;
    if (pool_valid !== 1'b1 || pool_col_num !== PCW'(1) || seq_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL seq_c3b got pv=%b pcn=%0d se=%b exp 1/1/0", pool_valid, pool_col_num, seq_err);
    end
    // Column 4 parks a large value; the restart must replace it.
    fill_data(16'h5000);
    drive_col(4);
    fill_data(16'h3C00);
    drive_col(0);
    vec_cnt++;
    if (seq_err !== 1'b1 || pool_valid !== 1'b0 || fsm_state !== 1'b1) begin
      err_cnt++;
      $display("FAIL seq_restart got se=%b pv=%b st=%b exp 1/0/1", seq_err, pool_valid, fsm_state);
    end
    fill_data(16'h3800);
    drive_col(1);
    vec_cnt++;
    if (pool_valid !== 1'b1 || pool_col_num !== PCW'(0) || seq_err !== 1'b0 || pool_data[5] !== 16'h3C00) begin
      err_cnt++;
      $display("FAIL seq_after_restart got pv=%b pcn=%0d se=%b d5=%h exp 1/0/0/3c00",
               pool_valid, pool_col_num, seq_err, pool_data[5]);
    end
  endtask

  task automatic test_back_to_back();
    int pv_n, done_n, se_n;
    pv_n = 0; done_n = 0; se_n = 0;
    do_reset();
    for (int i = 0; i < 2 * COLS; i++) begin
      fill_data(fp16_int(i % COLS));
      drive_col(i % COLS);
      if (pool_valid) pv_n++;
      if (done) done_n++;
      if (seq_err) se_n++;
      if (i % 2 == 1) begin
        vec_cnt++;
        if (pool_valid !== 1'b1 || pool_col_num !== PCW'((i % COLS) / 2) ||
            pool_data[3] !== fp16_int(i % COLS)) begin
          err_cnt++;
          $display("FAIL b2b_out i=%0d got pv=%b pcn=%0d d3=%h exp 1/%0d/%h", i, pool_valid,
                   pool_col_num, pool_data[3], (i % COLS) / 2, fp16_int(i % COLS));
        end
      end
    end
    vec_cnt++;
    if (pv_n != 24 || done_n != 2 || se_n != 0) begin
      err_cnt++;
      $display("FAIL b2b_counts got pv=%0d done=%0d se=%0d exp 24/2/0", pv_n, done_n, se_n);
    end
  endtask

  task automatic test_mid_reset();
    int pv_n, done_n;
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      fill_data(fp16_int(c + 1));
      drive_col(c);
    end
    // Reset coincides with column 5: reset wins.
    rst = 1'b1;
    col_valid = 1'b1;
    col_num = CW'(5);
    @(negedge clk);
    rst = 1'b0;
    col_valid = 1'b0;
    vec_cnt++;
    if (pool_valid !== 1'b0 || done !== 1'b0 || seq_err !== 1'b0 || pool_col_num !== '0 ||
        pool_data[0] !== 16'h0000 || fsm_state !== 1'b0) begin
      err_cnt++;
      $display("FAIL mid_reset_out got pv=%b done=%b se=%b pcn=%0d d0=%h st=%b exp all 0",
               pool_valid, done, seq_err, pool_col_num, pool_data[0], fsm_state);
    end
    drive_col(5);
    vec_cnt++;
    if (seq_err !== 1'b1 || pool_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL mid_reset_c5 got se=%b pv=%b exp 1/0", seq_err, pool_valid);
    end
    pv_n = 0; done_n = 0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) col_data[r] = fp16_int(r + c);
      drive_col(c);
      if (pool_valid) pv_n++;
      if (done) done_n++;
      if (c % 2 == 1) begin
        vec_cnt++;
        if (pool_col_num !== PCW'(c / 2) || pool_data[HR-1] !== fp16_int(ROWS - 1 + c)) begin
          err_cnt++;
          $display("FAIL mid_reset_frame col=%0d got pcn=%0d d11=%h exp %0d/%h", c, pool_col_num,
                   pool_data[HR-1], c / 2, fp16_int(ROWS - 1 + c));
        end
      end
    end
    vec_cnt++;
    if (pv_n != 12 || done_n != 1) begin
      err_cnt++;
      $display("FAIL mid_reset_counts got pv=%0d done=%0d exp 12/1", pv_n, done_n);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    fill_data(16'h0000);
    @(negedge clk);
    test_reset();
    test_ramp_frame();
    test_relu();
    test_max_compare();
    test_seq_err();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
